// File: rtl/counter_timer_ctrl_pkg.sv
// rtl/counter_timer_ctrl_pkg.sv - shared state encodings and mode constants for the timer controller
package counter_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_timer_ctrl_prescaler.sv
// rtl/counter_timer_ctrl_prescaler.sv - clock-enable prescaler counting 0..limit while enabled
module counter_timer_ctrl_prescaler #(
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] limit,
    output logic                 tc
);

    logic [PRE_WIDTH-1:0] count;

    // Terminal count is combinational so the counter steps on the same edge the prescaler wraps
    assign tc = en && (count == limit);

    // Count while enabled, wrap at limit; clear wins so a fresh config always starts aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == limit) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_timer_ctrl.sv
// rtl/counter_timer_ctrl.sv - programmable timer sequencer with configure/run/hold phases
module counter_timer_ctrl
    import counter_timer_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     cfg_period,
    input  logic [PRE_WIDTH-1:0] cfg_prescale,
    input  logic                 cfg_mode,
    input  logic                 start,
    input  logic                 stop,
    output logic [WIDTH-1:0]     value,
    output logic                 busy,
    output logic                 tick,
    output logic                 done
);

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     period_q;
    logic [PRE_WIDTH-1:0] prescale_q;
    logic                 mode_q;
    logic [WIDTH-1:0]     value_q;
    logic                 tick_q;
    logic                 done_q;

    logic                 cfg_acc;
    logic                 run_en;
    logic                 pre_tc;
    logic                 terminal;
    logic [WIDTH-1:0]     start_period;

    assign cfg_acc = cfg_valid && cfg_ready;
    // A stop edge is already a hold edge, so it must not count
    assign run_en  = (state_q == ST_RUN) && !stop;
    assign terminal = pre_tc && (value_q == period_q - WIDTH'(1));
    // A config arriving with the start is the period that start must honour
    assign start_period = cfg_acc ? cfg_period : period_q;

    counter_timer_ctrl_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_en),
        .clr     (cfg_acc),
        .limit   (prescale_q),
        .tc      (pre_tc)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop always beats a simultaneous start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (start_period != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (terminal && (mode_q == MODE_ONESHOT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cfg_ready = (state_q != ST_RUN);
        busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
    end

    // Configuration registers, loaded only on an accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q   <= '0;
            prescale_q <= '0;
            mode_q     <= MODE_ONESHOT;
        end else if (cfg_acc) begin
            period_q   <= cfg_period;
            prescale_q <= cfg_prescale;
            mode_q     <= cfg_mode;
        end
    end

    // Count value: cleared by config, stepped by the prescaler, wrapped at terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (cfg_acc) begin
            value_q <= '0;
        end else if (pre_tc) begin
            value_q <= terminal ? '0 : value_q + WIDTH'(1);
        end
    end

    // Event pulses, high only in the cycle after the terminal edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tick_q <= terminal;
            done_q <= terminal && (mode_q == MODE_ONESHOT);
        end
    end

    assign value = value_q;
    assign tick  = tick_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// tb/tb_counter_timer_ctrl.sv - directed self-checking bench for counter_timer_ctrl
module tb_counter_timer_ctrl;

    logic       clk;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [3:0] cfg_prescale;
    logic       cfg_mode;
    logic       start;
    logic       stop;
    logic [7:0] value;
    logic       busy;
    logic       tick;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    counter_timer_ctrl #(
        .WIDTH     (8),
        .PRE_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_mode     (cfg_mode),
        .start        (start),
        .stop         (stop),
        .value        (value),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] ps, input logic m);
        cfg_valid    = 1'b1;
        cfg_period   = p;
        cfg_prescale = ps;
        cfg_mode     = m;
        cyc();
        cfg_valid    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_prescale = '0;
        cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
        #2;
        chk("rst_value", 32'(value), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_done", 32'(done), 0);
        #6 reset_n = 1'b1;
        cyc();

        // periodic, period 5, prescale 0
        cfg(8'd5, 4'd0, 1'b1);
        chk("t1_cfg_value", 32'(value), 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(cfg_ready), 0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("t1_value_%0d", i), 32'(value), 32'(i % 5));
            chk($sformatf("t1_tick_%0d", i), 32'(tick), 32'(i % 5 == 0));
            chk($sformatf("t1_done_%0d", i), 32'(done), 0);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t1_hold_value", 32'(value), 2);
        chk("t1_hold_ready", 32'(cfg_ready), 1);

        // one-shot, period 3, prescale 2, configured in HOLD then resumed
        cfg(8'd3, 4'd2, 1'b0);
        chk("t2_cfg_value", 32'(value), 0);
        chk("t2_cfg_busy", 32'(busy), 1);
        start = 1'b1; cyc(); start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            cyc();
            chk($sformatf("t2_value_%0d", j), 32'(value), (j == 9) ? 0 : 32'(j / 3));
            chk($sformatf("t2_tick_%0d", j), 32'(tick), 32'(j == 9));
            chk($sformatf("t2_done_%0d", j), 32'(done), 32'(j == 9));
            chk($sformatf("t2_busy_%0d", j), 32'(busy), 32'(j != 9));
        end
        cyc();
        chk("t2_tick_clear", 32'(tick), 0);
        chk("t2_done_clear", 32'(done), 0);
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_ready", 32'(cfg_ready), 1);

        // period 0 is never started, with or without a same-cycle config
        cfg_valid = 1'b1; cfg_period = 8'd0; cfg_prescale = 4'd0; cfg_mode = 1'b1; start = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t5_zero_cfgstart_busy", 32'(busy), 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("t5_zero_start_busy", 32'(busy), 0);
        cyc();
        chk("t5_zero_tick", 32'(tick), 0);
        chk("t5_zero_value", 32'(value), 0);

        // config and start together, periodic period 6; stop at value 2 for four lost edges
        cfg_valid = 1'b1; cfg_period = 8'd6; cfg_prescale = 4'd0; cfg_mode = 1'b1; start = 1'b1;
        cyc();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        chk("t3_value0", 32'(value), 0);
        cyc(); cyc();
        chk("t3_value2", 32'(value), 2);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t3_hold0_value", 32'(value), 2);
        chk("t3_hold0_busy", 32'(busy), 1);
        cyc();
        chk("t3_hold1_value", 32'(value), 2);
        cyc();
        chk("t3_hold2_value", 32'(value), 2);
        chk("t3_hold2_tick", 32'(tick), 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("t3_resume_value", 32'(value), 2);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("t3_value_%0d", i), 32'(value), 32'((2 + i) % 6));
            chk($sformatf("t3_tick_%0d", i), 32'(tick), 32'(i == 4));
        end
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        chk("t3_both_ready", 32'(cfg_ready), 1);
        chk("t3_both_busy", 32'(busy), 1);
        cyc();
        chk("t3_both_value", 32'(value), 0);
        chk("t3_both_ready2", 32'(cfg_ready), 1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("t3_run_ready", 32'(cfg_ready), 0);

        // config refused in RUN, accepted in HOLD
        cfg_valid = 1'b1; cfg_period = 8'd9; cfg_prescale = 4'd0; cfg_mode = 1'b1;
        chk("t4_run_ready", 32'(cfg_ready), 0);
        cyc();
        cfg_valid = 1'b0;
        chk("t4_value1", 32'(value), 1);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("t4a_value_%0d", i), 32'(value), 32'((1 + i) % 6));
            chk($sformatf("t4a_tick_%0d", i), 32'(tick), 32'((1 + i) % 6 == 0));
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t4_hold_value", 32'(value), 1);
        cfg(8'd9, 4'd0, 1'b1);
        chk("t4_cfg_value", 32'(value), 0);
        chk("t4_cfg_busy", 32'(busy), 1);
        chk("t4_cfg_ready", 32'(cfg_ready), 1);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            chk($sformatf("t4b_value_%0d", i), 32'(value), 32'(i % 9));
            chk($sformatf("t4b_tick_%0d", i), 32'(tick), 32'(i % 9 == 0));
        end
        cyc(); cyc(); cyc(); cyc();
        chk("t6_pre_value", 32'(value), 4);

        // asynchronous reset mid-cycle while running
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_value", 32'(value), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_tick", 32'(tick), 0);
        chk("t6_rst_ready", 32'(cfg_ready), 1);
        #2 reset_n = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t6_start_ignored", 32'(busy), 0);
        cyc();
        chk("t6_idle_value", 32'(value), 0);

        // maximum period 255
        cfg(8'd255, 4'd0, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            cyc();
            if (i == 254) chk("t5_max_value254", 32'(value), 254);
            chk($sformatf("t5_max_tick_%0d", i), 32'(tick), 32'(i == 255));
        end
        chk("t5_max_wrap", 32'(value), 0);
        cyc();
        chk("t5_max_tick_clear", 32'(tick), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
